// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters. A grant is
// held across a locked multi-beat block transfer, up to MAXBEATS beats.
module ram_arbiter #(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned MAXBEATS = 2,
  parameter int unsigned WORD_W   = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req_ren,
  input  logic [NREQ-1:0]          req_wen,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ*WORD_W-1:0]   req_addr,
  input  logic [NREQ*WORD_W-1:0]   req_store,
  output logic [NREQ*WORD_W-1:0]   req_load,
  output logic [NREQ-1:0]          req_wait,
  output logic [NREQ-1:0]          req_err,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic [1:0]               ramstate,
  output logic                     grant_valid,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id
);

  localparam int unsigned IdW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BeatW = $clog2(MAXBEATS + 1);

  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e           state_q;
  logic [IdW-1:0]   owner_q;
  logic [IdW-1:0]   rr_ptr_q;
  logic [BeatW-1:0] beats_q;

  logic [NREQ-1:0]  cand;
  logic             found;
  logic [IdW-1:0]   pick;
  logic             ow_ren, ow_wen, ow_lock, ram_en;
  logic [IdW-1:0]   rr_next;
  logic             last_beat;
  logic [BeatW-1:0] beats_inc;

  assign cand = req_ren | req_wen;

  // Round-robin pick: first candidate scanning upward from rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && cand[idx[IdW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IdW-1:0];
      end
    end
  end

  // Owner-side decode and beat bookkeeping.
  always_comb begin
    ow_ren    = req_ren[owner_q];
    ow_wen    = req_wen[owner_q];
    ow_lock   = req_lock[owner_q];
    ram_en    = ow_ren | ow_wen;
    rr_next   = (int'(owner_q) == int'(NREQ) - 1) ? '0 : owner_q + 1'b1;
    last_beat = (int'(beats_q) + 1) >= int'(MAXBEATS);
    beats_inc = (beats_q == BeatW'(MAXBEATS)) ? beats_q : beats_q + 1'b1;
  end

  // Port muxing: everything driven from the registered owner while in StOwn.
  always_comb begin
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    req_load    = '0;
    req_wait    = '1;
    req_err     = '0;
    grant_valid = 1'b0;
    grant_id    = '0;
    if (state_q == StOwn) begin
      ramWEN      = ow_wen;
      ramREN      = ow_ren & ~ow_wen;  // write wins when both are set
      ramaddr     = req_addr[owner_q*WORD_W +: WORD_W];
      ramstore    = req_store[owner_q*WORD_W +: WORD_W];
      req_load[owner_q*WORD_W +: WORD_W] = ramload;
      req_wait[owner_q] = (ramstate != RamAccess);
      req_err[owner_q]  = (ramstate == RamError);
      grant_valid = 1'b1;
      grant_id    = owner_q;
    end
  end

  // Grant FSM: arbitrate in StIdle, hold/release in StOwn.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beats_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            state_q <= StOwn;
            owner_q <= pick;
            beats_q <= '0;
          end
        end
        StOwn: begin
          if (ramstate == RamError) begin
            // Owner retries through a fresh arbitration.
            state_q  <= StIdle;
            rr_ptr_q <= rr_next;
            beats_q  <= '0;
          end else if (ram_en) begin
            if (ramstate == RamAccess) begin
              if (ow_lock && !last_beat) begin
                beats_q <= beats_inc;
              end else begin
                state_q  <= StIdle;
                rr_ptr_q <= rr_next;
                beats_q  <= '0;
              end
            end
          end else if (!ow_lock) begin
            // Owner dropped its request without lock: abort, no beat counted.
            state_q  <= StIdle;
            rr_ptr_q <= rr_next;
            beats_q  <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and random bench for ram_arbiter against a behavioural grant model.
module tb_ram_arbiter;

  localparam int NREQ = 3;
  localparam int MAXBEATS = 2;
  localparam int W = 32;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   req_ren, req_wen, req_lock;
  logic [NREQ*W-1:0] req_addr, req_store, req_load;
  logic [NREQ-1:0]   req_wait, req_err;
  logic              ramREN, ramWEN;
  logic [W-1:0]      ramaddr, ramstore, ramload;
  logic [1:0]        ramstate;
  logic              grant_valid;
  logic [1:0]        grant_id;

  int errors = 0;
  int checks = 0;

  // Reference model: who holds the port, next priority slot, beats done.
  bit m_own;
  int m_owner;
  int m_ptr;
  int m_beats;

  always #5 CLK = ~CLK;

  ram_arbiter #(.NREQ(NREQ), .MAXBEATS(MAXBEATS), .WORD_W(W)) dut (
    .CLK(CLK), .RST(RST),
    .req_ren(req_ren), .req_wen(req_wen), .req_lock(req_lock),
    .req_addr(req_addr), .req_store(req_store), .req_load(req_load),
    .req_wait(req_wait), .req_err(req_err),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    req_ren = '0; req_wen = '0; req_lock = '0;
    req_addr = '0; req_store = '0;
  endtask

  task automatic set_req(input int i, input bit r, input bit w, input bit l,
                         input logic [W-1:0] a, input logic [W-1:0] s);
    req_ren[i] = r; req_wen[i] = w; req_lock[i] = l;
    req_addr[i*W +: W] = a; req_store[i*W +: W] = s;
  endtask

  // One clock: entered at a falling edge with inputs set; checks every output
  // against the model, advances the model at the rising edge.
  task automatic step();
    logic [NREQ-1:0] e_wait, e_err;
    logic [NREQ*W-1:0] e_load;
    logic e_ren, e_wen, e_gv;
    logic [W-1:0] e_addr, e_store;
    int e_gid, o, best, bestd, d;
    bit n_own, rel;
    int n_owner, n_ptr, n_beats;
    #1;
    e_wait = '1; e_err = '0; e_load = '0; e_ren = 0; e_wen = 0; e_gv = 0;
    e_addr = '0; e_store = '0; e_gid = 0; o = m_owner;
    if (m_own) begin
      e_wen = req_wen[o];
      e_ren = req_ren[o] && !req_wen[o];
      e_addr = req_addr[o*W +: W];
      e_store = req_store[o*W +: W];
      e_load[o*W +: W] = ramload;
      e_wait[o] = (ramstate != 2'd2);
      e_err[o] = (ramstate == 2'd3);
      e_gv = 1; e_gid = o;
    end
    chk("grant_valid", grant_valid, e_gv);
    chk("grant_id", grant_id, e_gid);
    chk("ramREN", ramREN, e_ren);
    chk("ramWEN", ramWEN, e_wen);
    chk("ramaddr", ramaddr, e_addr);
    chk("ramstore", ramstore, e_store);
    chk("req_load", req_load, e_load);
    chk("req_wait", req_wait, e_wait);
    chk("req_err", req_err, e_err);

    n_own = m_own; n_owner = m_owner; n_ptr = m_ptr; n_beats = m_beats;
    if (RST) begin
      n_own = 0; n_owner = 0; n_ptr = 0; n_beats = 0;
    end else if (!m_own) begin
      best = -1; bestd = NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ren[i] || req_wen[i]) begin
          d = (i - m_ptr + NREQ) % NREQ;
          if (d < bestd) begin bestd = d; best = i; end
        end
      end
      if (best >= 0) begin n_own = 1; n_owner = best; n_beats = 0; end
    end else begin
      rel = 0;
      if (ramstate == 2'd3) rel = 1;
      else if (e_ren || e_wen) begin
        if (ramstate == 2'd2) begin
          if (req_lock[o] && (m_beats + 1 < MAXBEATS)) n_beats = m_beats + 1;
          else rel = 1;
        end
      end else if (!req_lock[o]) rel = 1;
      if (rel) begin n_own = 0; n_ptr = (o + 1) % NREQ; n_beats = 0; end
    end
    @(posedge CLK);
    m_own = n_own; m_owner = n_owner; m_ptr = n_ptr; m_beats = n_beats;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1; step(); RST = 0;
  endtask

  initial begin
    RST = 1; clear_reqs(); ramload = '0; ramstate = 2'd0;
    m_own = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
    @(posedge CLK); @(negedge CLK);
    do_reset();

    // Single read by requester 1.
    set_req(1, 1, 0, 0, 32'h40, 32'h0); ramstate = 2'd0; step();
    ramstate = 2'd1; #1;
    chk("read_ren", ramREN, 1'b1);
    chk("read_addr", ramaddr, 32'h40);
    step();
    ramstate = 2'd2; ramload = 32'hDEADBEEF; #1;
    chk("read_load", req_load[63:32], 32'hDEADBEEF);
    chk("read_wait", req_wait, 3'b101);
    step();
    req_ren = '0; ramstate = 2'd0; #1;
    chk("read_release", grant_valid, 1'b0);
    step();
    req_ren = 3'b111; step();  // rr_ptr now 2
    ramstate = 2'd2; #1;
    chk("read_rrptr", grant_id, 2'd2);
    step();

    // Contention: grants rotate 0,1,2,...
    clear_reqs(); do_reset();
    req_ren = 3'b111; ramstate = 2'd2;
    for (int c = 0; c < 12; c++) begin
      if (c % 2 == 1) begin
        #1; chk("rr_seq", grant_id, (c / 2) % 3);
      end
      step();
    end

    // Locked two-beat write by requester 2 with a gap; requester 0 pending.
    clear_reqs(); do_reset();
    set_req(2, 0, 1, 1, 32'h80, 32'h1111); ramstate = 2'd0; step();
    req_ren[0] = 1; ramstate = 2'd2; #1;
    chk("lock_gid", grant_id, 2'd2);
    chk("lock_addr0", ramaddr, 32'h80);
    step();
    req_wen[2] = 0; ramstate = 2'd0; #1;
    chk("lock_gap_wen", ramWEN, 1'b0);
    chk("lock_gap_hold", grant_valid, 1'b1);
    step();
    set_req(2, 0, 1, 1, 32'h84, 32'h2222); ramstate = 2'd2; #1;
    chk("lock_addr1", ramaddr, 32'h84);
    step();
    req_wen[2] = 0; req_lock[2] = 0; step();
    ramstate = 2'd2; #1;
    chk("lock_next", grant_id, 2'd0);
    step();

    // Forced release after MAXBEATS beats despite lock.
    clear_reqs(); do_reset();
    set_req(1, 0, 1, 1, 32'hA0, 32'h5); ramstate = 2'd2;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) begin
        #1; chk("forced_release", grant_valid, 1'b0);
      end
      step();
    end

    // Error during a read by requester 0.
    clear_reqs(); do_reset();
    set_req(0, 1, 0, 0, 32'h10, 32'h0); ramstate = 2'd0; step();
    ramstate = 2'd3; #1;
    chk("err_pulse", req_err, 3'b001);
    chk("err_wait", req_wait, 3'b111);
    step();
    ramstate = 2'd0; #1;
    chk("err_once", req_err, 3'b000);
    chk("err_idle", grant_valid, 1'b0);
    step();

    // Reset in the middle of a transfer.
    clear_reqs(); do_reset();
    set_req(1, 1, 0, 0, 32'h20, 32'h0); step();
    ramstate = 2'd1; RST = 1; #1;
    chk("rst_pre_ren", ramREN, 1'b1);
    step();
    RST = 0; req_ren[2] = 1; #1;
    chk("rst_ren", ramREN, 1'b0);
    chk("rst_gv", grant_valid, 1'b0);
    step();
    #1; chk("rst_first", grant_id, 2'd1);
    step();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NREQ; i++) begin
        set_req(i, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                $urandom_range(0, 1) == 1, $urandom, $urandom);
      end
      ramload = $urandom;
      ramstate = 2'($urandom_range(0, 3));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
